// File: rtl/req_index_encoder.sv
// req_index_encoder: serializes sticky 32-bit request strobes into 5-bit indices over valid/ready.
// Define ROUND_ROBIN_EN for round-robin selection; otherwise the lowest pending index wins.
module req_index_encoder #(
  parameter int NUM_REQ = 32,
  parameter int IDX_W = 5
) (
  input  logic               clock,
  input  logic               ctrl_reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] pending,
  output logic               req_merged
);
  typedef enum logic [1:0] {IDLE, SELECT, PRESENT} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d, req_en, clr;
  logic [IDX_W-1:0] index_q, index_d, pick;
  logic merged_q, merged_d, xfer;
  assign xfer = state_q == PRESENT && out_ready;
  assign req_en = req & {NUM_REQ{enable}};
  assign clr = xfer ? NUM_REQ'(1) << index_q : '0;
  // A new request for the bit being transferred re-sets it: set wins over clear.
  assign pending_d = (pending_q & ~clr) | req_en;
  assign merged_d = |(req_en & pending_q & ~clr);
`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d, off;
  always_comb begin
    off = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) if (pending_d[ptr_q + IDX_W'(i)]) off = IDX_W'(i);
  end
  assign pick = ptr_q + off;
  assign ptr_d = xfer ? index_q + 1'b1 : ptr_q;
  always_ff @(posedge clock or negedge ctrl_reset_n)
    if (!ctrl_reset_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
`else
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) if (pending_d[i]) pick = IDX_W'(i);
  end
`endif
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    case (state_q)
      IDLE: state_d = |pending_d ? SELECT : IDLE;
      SELECT: begin
        index_d = pick;
        state_d = PRESENT;
      end
      PRESENT: if (xfer) state_d = |pending_d ? SELECT : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge ctrl_reset_n)
    if (!ctrl_reset_n) begin
      state_q <= IDLE;
      pending_q <= '0;
      index_q <= '0;
      merged_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      index_q <= index_d;
      merged_q <= merged_d;
    end
  assign out_valid = state_q == PRESENT;
  assign out_index = index_q;
  assign pending = pending_q;
  assign req_merged = merged_q;
endmodule
